// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-port memory between fetch and data ports
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_width,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

    generate
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("unified_mem_arbiter: MEM_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [1:0]        width_q, width_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              d_win, done;

    // owner/last flags: 1 = data port, 0 = fetch port
    always_comb begin
        d_win   = d_req && (!i_req || !last_q);
        i_gnt   = state_q == IDLE && !rst && i_req && !d_win;
        d_gnt   = state_q == IDLE && !rst && d_win;
        done    = state_q == ACCESS && cnt_q == '0 && !rst;
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (i_gnt || d_gnt) begin
            state_d = ACCESS;
            cnt_d   = LAT;
            owner_d = d_gnt;
            last_d  = d_gnt;
            we_d    = d_gnt && d_we;
            width_d = d_gnt ? d_width : 2'b10;
            addr_d  = d_gnt ? d_addr : i_addr;
            wdata_d = (d_gnt && d_we) ? d_wdata : '0;
        end else if (state_q == ACCESS) begin
            state_d = cnt_q == '0 ? IDLE : ACCESS;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            width_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy      = state_q == ACCESS;
    assign mem_en    = busy && cnt_q == LAT && !rst;
    assign mem_we    = we_q;
    assign mem_width = width_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rvalid  = done && !owner_q;
    assign d_rvalid  = done && owner_q;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vector table plus hand sequences for multi-cycle corners
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [1:0]  d_width = 2'b00;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [1:0]  mem_width;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    int          checks = 0, errors = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // flg = {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy}
    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr, dwe;
        logic [1:0]  dw;
        logic [31:0] da, dd, mr;
        logic [6:0]  flg;
        logic [1:0]  mw;
        logic [31:0] ird, drd, ma, mwd;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_rdata = '0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000000, 2'b00, 32'h0,        32'h0,  32'h0,   32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000000, 2'b00, 32'h0,        32'h0,  32'h0,   32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b1000000, 2'b00, 32'h0,        32'h0,  32'h0,   32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000101, 2'b10, 32'h0,        32'h0,  32'h10,  32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000001, 2'b10, 32'h0,        32'h0,  32'h10,  32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h00A00093, 7'b0010001, 2'b10, 32'h00A00093, 32'h0,  32'h10,  32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 2'b01, 32'h104, 32'hBEEF, 32'h0,        7'b0100000, 2'b10, 32'h0,        32'h0,  32'h10,  32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000111, 2'b01, 32'h0,        32'h0,  32'h104, 32'hBEEF};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000011, 2'b01, 32'h0,        32'h0,  32'h104, 32'hBEEF};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h12345678, 7'b0001011, 2'b01, 32'h0,        32'h0,  32'h104, 32'hBEEF};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b00, 32'h3,   32'hFFFF, 32'h0,        7'b0100010, 2'b01, 32'h0,        32'h0,  32'h104, 32'hBEEF};
        tbl[11] = '{1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000101, 2'b00, 32'h0,        32'h0,  32'h3,   32'h0};
        tbl[12] = '{1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b0000001, 2'b00, 32'h0,        32'h0,  32'h3,   32'h0};
        tbl[13] = '{1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h000000AB, 7'b0001001, 2'b00, 32'h0,        32'hAB, 32'h3,   32'h0};
        tbl[14] = '{1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,    32'h0,        7'b1000000, 2'b00, 32'h0,        32'h0,  32'h3,   32'h0};

        for (int i = 0; i < 15; i++) begin
            nxt();
            rst = tbl[i].rst; i_req = tbl[i].ir; i_addr = tbl[i].ia;
            d_req = tbl[i].dr; d_we = tbl[i].dwe; d_width = tbl[i].dw;
            d_addr = tbl[i].da; d_wdata = tbl[i].dd; mem_rdata = tbl[i].mr;
            smp();
            chk($sformatf("vec%0d", i),
                160'({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy, mem_width, i_rdata, d_rdata, mem_addr, mem_wdata}),
                160'({tbl[i].flg, tbl[i].mw, tbl[i].ird, tbl[i].drd, tbl[i].ma, tbl[i].mwd}));
        end

        // both requesters held from reset release: D,I,D,I every 4 cycles
        do_reset();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h200;
        for (int k = 0; k < 16; k++) begin
            logic odd, g, v;
            odd = ((k / 4) % 2) == 1;
            g = (k % 4) == 0;
            v = (k % 4) == 3;
            smp();
            chk($sformatf("alt k%0d", k), 160'({i_gnt, d_gnt, i_rvalid, d_rvalid}),
                160'({g && odd, g && !odd, v && odd, v && !odd}));
            nxt();
        end

        // reset in the middle of a data access
        do_reset();
        d_req = 1'b1; d_addr = 32'h40;
        smp();
        chk("abort gnt", 160'(d_gnt), 160'(1'b1));
        nxt();
        d_req = 1'b0;
        nxt();
        rst = 1'b1;
        smp();
        chk("abort rst", 160'({d_rvalid, i_gnt, d_gnt, mem_en}), 160'(4'b0000));
        nxt();
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h80;
        smp();
        chk("abort regrant", 160'({busy, d_rvalid, mem_en, i_gnt}), 160'(4'b0001));
        nxt();
        i_req = 1'b0;
        smp();
        chk("abort fetch en", 160'({mem_en, mem_addr}), 160'({1'b1, 32'h80}));
        nxt();
        smp();
        chk("abort quiet", 160'({i_rvalid, d_rvalid}), 160'(2'b00));
        nxt();
        smp();
        chk("abort rvalid", 160'({i_rvalid, d_rvalid}), 160'(2'b10));

        // fetch arriving during a data access waits for IDLE
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        smp();
        chk("late d_gnt", 160'({i_gnt, d_gnt}), 160'(2'b01));
        nxt();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h400;
        for (int k = 1; k <= 7; k++) begin
            smp();
            chk($sformatf("late k%0d", k), 160'({i_gnt, d_gnt, i_rvalid, d_rvalid}),
                160'({k == 4, 1'b0, k == 7, k == 3}));
            nxt();
            if (k == 4) i_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
